// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: tick is high on the last clock cycle of each UART bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends each as an 8N1 (or 8E1) UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  tx_state_t                   state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        parity_q, parity_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic                        baud_clear;
  logic                        bit_tick;

  // Counter is held at zero outside the bit-timed states so START begins a full period.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    fifo_rd_en = 1'b0;
    tx         = UART_IDLE_LEVEL;
    busy       = (state_q != ST_IDLE);
    frame_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fifo_rd_en = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        // FIFO output is valid now, one cycle after the read strobe.
        shift_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_idx_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        tx = parity_q;
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx         = UART_IDLE_LEVEL;
        frame_done = bit_tick;
        if (bit_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (no parity / even parity) each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       empty0, empty1;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;

  int errors = 0;
  int checks = 0;

  // FIFO models with registered read: data appears the cycle after the read strobe.
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int wr0 = 0, rp0 = 0, wr1 = 0, rp1 = 0;
  assign empty0 = (wr0 == rp0);
  assign empty1 = (wr1 == rp1);

  always @(posedge clk) begin
    if (rd0 && (wr0 != rp0)) begin
      data0 <= mem0[rp0 % 64];
      rp0   <= rp0 + 1;
    end
    if (rd1 && (wr1 != rp1)) begin
      data1 <= mem1[rp1 % 64];
      rp1   <= rp1 + 1;
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(empty0), .fifo_data(data0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(empty1), .fifo_data(data1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  // Per-cycle log of outputs, sampled on the falling edge.
  logic log_tx   [0:1][0:4095];
  logic log_rd   [0:1][0:4095];
  logic log_fd   [0:1][0:4095];
  logic log_busy [0:1][0:4095];
  int   cyc = 0;

  always @(negedge clk) begin
    if (cyc < 4096) begin
      log_tx[0][cyc] = tx0;   log_tx[1][cyc] = tx1;
      log_rd[0][cyc] = rd0;   log_rd[1][cyc] = rd1;
      log_fd[0][cyc] = fd0;   log_fd[1][cyc] = fd1;
      log_busy[0][cyc] = busy0; log_busy[1][cyc] = busy1;
    end
    cyc = cyc + 1;
  end

  task automatic push(input int d, input logic [7:0] b);
    if (d == 0) begin
      mem0[wr0 % 64] = b;
      wr0 = wr0 + 1;
    end else begin
      mem1[wr1 % 64] = b;
      wr1 = wr1 + 1;
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input bit par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par && k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic int frame_errs(input int d, input int s, input logic [7:0] b, input bit par);
    int n = 0;
    int nb = par ? 11 : 10;
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < 4; c++)
        if (log_tx[d][s + 4*k + c] !== exp_bit(b, par, k)) n++;
    return n;
  endfunction

  function automatic int find_fall(input int d, input int from, input int upto);
    for (int i = from; i <= upto; i++)
      if (log_tx[d][i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_rd(input int d, input int from, input int upto);
    int n = 0;
    for (int i = from; i <= upto; i++) if (log_rd[d][i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_fd(input int d, input int from, input int upto);
    int n = 0;
    for (int i = from; i <= upto; i++) if (log_fd[d][i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    int bad_tx, bad_busy, bad_rd;
    reset = 1'b1;
    tx_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (fd1 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", fd1); end
    bad_tx = 0; bad_busy = 0; bad_rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || tx1 !== 1'b1) bad_tx++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) bad_busy++;
      if (rd0 !== 1'b0 || rd1 !== 1'b0) bad_rd++;
    end
    checks++; if (bad_tx !== 0) begin errors++; $display("FAIL empty_idle_tx: %0d bad cycles, want 0", bad_tx); end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL empty_idle_busy: %0d bad cycles, want 0", bad_busy); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL empty_idle_rd: %0d bad cycles, want 0", bad_rd); end
  endtask

  task automatic test_single_a5();
    int base, s;
    @(posedge clk); #2;
    base = cyc;
    push(0, 8'hA5);
    repeat (60) @(negedge clk);
    s = find_fall(0, base, cyc - 2);
    checks++;
    if (s != base + 3) begin errors++; $display("FAIL a5_latency: start at %0d want %0d", s, base + 3); end
    if (s < 2) return;
    checks++; if (log_rd[0][s-2] !== 1'b1) begin errors++; $display("FAIL a5_rd_pos: got %b want 1", log_rd[0][s-2]); end
    checks++; if (count_rd(0, base, cyc - 2) != 1) begin errors++; $display("FAIL a5_rd_count: got %0d want 1", count_rd(0, base, cyc - 2)); end
    checks++; if (frame_errs(0, s, 8'hA5, 1'b0) != 0) begin errors++; $display("FAIL a5_line: %0d bad cycles want 0", frame_errs(0, s, 8'hA5, 1'b0)); end
    checks++; if (log_tx[0][s+4] !== 1'b1 || log_tx[0][s+8] !== 1'b0) begin errors++; $display("FAIL a5_lsb_first: bit0=%b bit1=%b want 1 0", log_tx[0][s+4], log_tx[0][s+8]); end
    checks++; if (log_fd[0][s+39] !== 1'b1 || count_fd(0, base, cyc - 2) != 1) begin errors++; $display("FAIL a5_frame_done: at_end=%b count=%0d want 1 1", log_fd[0][s+39], count_fd(0, base, cyc - 2)); end
    checks++; if (log_busy[0][s+39] !== 1'b1 || log_busy[0][s+40] !== 1'b0) begin errors++; $display("FAIL a5_frame_len: busy %b%b want 10", log_busy[0][s+39], log_busy[0][s+40]); end
  endtask

  task automatic test_parity();
    int base, s, s2;
    @(posedge clk); #2;
    base = cyc;
    push(1, 8'hA5);
    push(1, 8'h07);
    repeat (120) @(negedge clk);
    s = find_fall(1, base, cyc - 2);
    checks++;
    if (s < 0) begin errors++; $display("FAIL par_start: no start bit seen"); return; end
    s2 = find_fall(1, s + 44, cyc - 2);
    checks++; if (log_tx[1][s+37] !== 1'b0) begin errors++; $display("FAIL par_a5_bit: got %b want 0", log_tx[1][s+37]); end
    checks++; if (frame_errs(1, s, 8'hA5, 1'b1) != 0) begin errors++; $display("FAIL par_a5_line: %0d bad cycles want 0", frame_errs(1, s, 8'hA5, 1'b1)); end
    checks++; if (log_fd[1][s+43] !== 1'b1) begin errors++; $display("FAIL par_a5_len: frame_done at +43 got %b want 1", log_fd[1][s+43]); end
    checks++;
    if (s2 != s + 47) begin errors++; $display("FAIL par_gap: second start %0d want %0d", s2, s + 47); return; end
    checks++; if (log_tx[1][s2+37] !== 1'b1) begin errors++; $display("FAIL par_07_bit: got %b want 1", log_tx[1][s2+37]); end
    checks++; if (frame_errs(1, s2, 8'h07, 1'b1) != 0) begin errors++; $display("FAIL par_07_line: %0d bad cycles want 0", frame_errs(1, s2, 8'h07, 1'b1)); end
    checks++; if (count_fd(1, base, cyc - 2) != 2) begin errors++; $display("FAIL par_done_count: got %0d want 2", count_fd(1, base, cyc - 2)); end
  endtask

  task automatic test_back_to_back();
    int base, s1, s2, s3;
    @(posedge clk); #2;
    base = cyc;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    repeat (150) @(negedge clk);
    s1 = find_fall(0, base, cyc - 2);
    s2 = (s1 < 0) ? -1 : find_fall(0, s1 + 40, cyc - 2);
    s3 = (s2 < 0) ? -1 : find_fall(0, s2 + 40, cyc - 2);
    checks++;
    if (s1 < 0 || s2 != s1 + 43 || s3 != s2 + 43) begin
      errors++; $display("FAIL b2b_spacing: starts %0d %0d %0d want gaps of 43", s1, s2, s3); return;
    end
    checks++; if (frame_errs(0, s1, 8'h11, 1'b0) != 0) begin errors++; $display("FAIL b2b_11: %0d bad cycles want 0", frame_errs(0, s1, 8'h11, 1'b0)); end
    checks++; if (frame_errs(0, s2, 8'h22, 1'b0) != 0) begin errors++; $display("FAIL b2b_22: %0d bad cycles want 0", frame_errs(0, s2, 8'h22, 1'b0)); end
    checks++; if (frame_errs(0, s3, 8'h33, 1'b0) != 0) begin errors++; $display("FAIL b2b_33: %0d bad cycles want 0", frame_errs(0, s3, 8'h33, 1'b0)); end
    checks++; if ({log_tx[0][s2-3], log_tx[0][s2-2], log_tx[0][s2-1]} !== 3'b111) begin errors++; $display("FAIL b2b_gap_high: got %b%b%b want 111", log_tx[0][s2-3], log_tx[0][s2-2], log_tx[0][s2-1]); end
    checks++; if (count_rd(0, base, cyc - 2) != 3) begin errors++; $display("FAIL b2b_rd_count: got %0d want 3", count_rd(0, base, cyc - 2)); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy0); end
  endtask

  task automatic test_tx_en_drop();
    int base, base2, s, s2, waited;
    @(posedge clk); #2;
    base = cyc;
    push(0, 8'h5A);
    push(0, 8'h3C);
    waited = 0;
    do begin @(negedge clk); waited++; end while (tx0 !== 1'b0 && waited < 20);
    checks++;
    if (tx0 !== 1'b0) begin errors++; $display("FAIL txen_start: timeout, tx=%b want 0", tx0); return; end
    repeat (9) @(negedge clk);
    tx_en = 1'b0;
    repeat (80) @(negedge clk);
    s = find_fall(0, base, cyc - 2);
    checks++; if (frame_errs(0, s, 8'h5A, 1'b0) != 0) begin errors++; $display("FAIL txen_frame: %0d bad cycles want 0", frame_errs(0, s, 8'h5A, 1'b0)); end
    checks++; if (count_rd(0, base, cyc - 2) != 1) begin errors++; $display("FAIL txen_rd_held: got %0d reads want 1", count_rd(0, base, cyc - 2)); end
    checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin errors++; $display("FAIL txen_idle: busy=%b tx=%b want 0 1", busy0, tx0); end
    tx_en = 1'b1;
    base2 = cyc;
    repeat (60) @(negedge clk);
    s2 = find_fall(0, base2, cyc - 2);
    checks++;
    if (s2 < 0) begin errors++; $display("FAIL txen_resume: no frame after tx_en rose"); return; end
    checks++; if (frame_errs(0, s2, 8'h3C, 1'b0) != 0) begin errors++; $display("FAIL txen_resume_frame: %0d bad cycles want 0", frame_errs(0, s2, 8'h3C, 1'b0)); end
  endtask

  task automatic test_reset_mid();
    int base, s, s2, waited;
    @(posedge clk); #2;
    base = cyc;
    push(0, 8'h96);
    push(0, 8'h69);
    waited = 0;
    do begin @(negedge clk); waited++; end while (tx0 !== 1'b0 && waited < 20);
    checks++;
    if (tx0 !== 1'b0) begin errors++; $display("FAIL rst_start: timeout, tx=%b want 0", tx0); return; end
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid: tx=%b busy=%b want 1 0", tx0, busy0); end
    reset = 1'b0;
    repeat (70) @(negedge clk);
    s = find_fall(0, base, cyc - 2);
    s2 = find_fall(0, s + 19, cyc - 2);
    checks++; if (count_fd(0, base, s + 19) != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", count_fd(0, base, s + 19)); end
    checks++;
    if (s2 != s + 21) begin errors++; $display("FAIL rst_refetch: next start %0d want %0d", s2, s + 21); return; end
    checks++; if (frame_errs(0, s2, 8'h69, 1'b0) != 0) begin errors++; $display("FAIL rst_next_byte: %0d bad cycles want 0", frame_errs(0, s2, 8'h69, 1'b0)); end
    checks++; if (count_rd(0, base, cyc - 2) != 2) begin errors++; $display("FAIL rst_rd_count: got %0d want 2", count_rd(0, base, cyc - 2)); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_parity();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
